axi_lite_ram_slave: RTL and testbench

- AXI-Lite style memory responder with a single-port, byte-enabled word RAM behind it.
- Connects to one s_axi_* slave port of the system interconnect. The interconnect's default map puts it at slave 1, 0x1000_0000.
- Write and read channels run independent FSMs, each with one outstanding transaction. The slave echoes IDs, decodes range errors, and has configurable read latency.

---
 rtl/axi_lite_pkg.sv | 10 +
 rtl/axi_lite_ram_slave_if.sv | 42 ++++
 rtl/axi_excl_monitor.sv | 35 +++
 rtl/axi_lite_ram_slave.sv | 194 +++++++++++++++++++
 tb/tb_axi_lite_ram_slave.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: shared AXI-Lite response codes and channel FSM state types
package axi_lite_pkg;
  typedef logic [1:0] resp_t;
  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_EXOKAY = 2'b01;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;
  typedef enum logic [1:0] {W_IDLE, W_NEED_AW, W_NEED_W, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_e;
endpackage

// File: rtl/axi_lite_ram_slave_if.sv
// axi_lite_ram_slave_if: AXI-Lite write/read channel bundle with master and slave views
interface axi_lite_ram_slave_if import axi_lite_pkg::*; #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
);
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awlock;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [ID_WIDTH-1:0]     bid;
  resp_t                   bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arlock;
  logic                    arvalid;
  logic                    arready;
  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  resp_t                   rresp;
  logic                    rvalid;
  logic                    rready;
  modport master (
    output awid, awaddr, awprot, awlock, awvalid, wdata, wstrb, wvalid, bready,
           arid, araddr, arprot, arlock, arvalid, rready,
    input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rvalid
  );
  modport slave (
    input  awid, awaddr, awprot, awlock, awvalid, wdata, wstrb, wvalid, bready,
           arid, araddr, arprot, arlock, arvalid, rready,
    output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_excl_monitor.sv
// axi_excl_monitor: single exclusive-access reservation {valid, id, index} with write match
module axi_excl_monitor import axi_lite_pkg::*; #(
  parameter int ID_WIDTH = 4,
  parameter int IDX_W    = 10
)(
  input  logic                clk,
  input  logic                rst,
  input  logic                set_i,
  input  logic [ID_WIDTH-1:0] set_id_i,
  input  logic [IDX_W-1:0]    set_idx_i,
  input  logic                wr_i,
  input  logic                wr_excl_i,
  input  logic [ID_WIDTH-1:0] wr_id_i,
  input  logic [IDX_W-1:0]    wr_idx_i,
  output logic                match_o
);
  logic                v_q;
  logic [ID_WIDTH-1:0] id_q;
  logic [IDX_W-1:0]    idx_q;
  logic                clr;
  assign match_o = v_q && id_q == wr_id_i && idx_q == wr_idx_i;
  // a failed exclusive write stores nothing, so only a successful one releases the reservation
  assign clr = wr_i && (wr_excl_i ? match_o : v_q && idx_q == wr_idx_i);
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= 1'b0;
    end else if (set_i) begin
      v_q   <= 1'b1;
      id_q  <= set_id_i;
      idx_q <= set_idx_i;
    end else if (clr) begin
      v_q <= 1'b0;
    end
  end
endmodule

// File: rtl/axi_lite_ram_slave.sv
// axi_lite_ram_slave: AXI-Lite byte-enabled word RAM responder with independent write/read FSMs
// Define AXI_EXCL_MON_EN to enable exclusive access (awlock/arlock) via axi_excl_monitor.
module axi_lite_ram_slave import axi_lite_pkg::*; #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    ID_WIDTH     = 4,
  parameter int                    DEPTH        = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 'h1000_0000,
  parameter int                    READ_LATENCY = 1
)(
  input logic                 clk,
  input logic                 rst,
  axi_lite_ram_slave_if.slave s_axi
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(DEPTH * BYTES);
  localparam logic [1:0] CNT_INIT = 2'(READ_LATENCY - 1);

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return (a - BASE_ADDR) < SPAN;
  endfunction

  function automatic logic [IDX_W-1:0] to_idx(input logic [ADDR_WIDTH-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> OFF_W);
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  w_state_e              w_state_q, w_state_d;
  logic                  awready_q, wready_q, bvalid_q;
  logic [ID_WIDTH-1:0]   bid_q, awid_q;
  resp_t                 bresp_q;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic                  awlock_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [BYTES-1:0]      wstrb_q;
  logic                  aw_hs, w_hs, b_hs, w_fire, w_in, w_ok, w_exok, aw_lock;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [ID_WIDTH-1:0]   w_id;
  logic [DATA_WIDTH-1:0] w_data;
  logic [BYTES-1:0]      w_strb;
  logic [IDX_W-1:0]      w_idx;

  assign aw_hs  = awready_q && s_axi.awvalid;
  assign w_hs   = wready_q && s_axi.wvalid;
  assign b_hs   = bvalid_q && s_axi.bready;
  assign w_fire = (w_state_q == W_IDLE && aw_hs && w_hs) || (w_state_q == W_NEED_W && w_hs) ||
                  (w_state_q == W_NEED_AW && aw_hs);
  assign w_state_d = w_fire ? W_RESP :
                     (w_state_q == W_IDLE && aw_hs) ? W_NEED_W :
                     (w_state_q == W_IDLE && w_hs) ? W_NEED_AW :
                     b_hs ? W_IDLE : w_state_q;
  // whichever half arrived first is replayed from its capture register
  assign w_addr  = w_state_q == W_NEED_W ? awaddr_q : s_axi.awaddr;
  assign w_id    = w_state_q == W_NEED_W ? awid_q : s_axi.awid;
  assign aw_lock = w_state_q == W_NEED_W ? awlock_q : s_axi.awlock;
  assign w_data  = w_state_q == W_NEED_AW ? wdata_q : s_axi.wdata;
  assign w_strb  = w_state_q == W_NEED_AW ? wstrb_q : s_axi.wstrb;
  assign w_in    = in_range(w_addr);
  assign w_idx   = to_idx(w_addr);

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      awready_q <= w_state_d == W_IDLE || w_state_d == W_NEED_AW;
      wready_q  <= w_state_d == W_IDLE || w_state_d == W_NEED_W;
      bvalid_q  <= w_fire || (bvalid_q && !s_axi.bready);
      if (w_fire) begin
        bid_q   <= w_id;
        bresp_q <= !w_in ? RESP_SLVERR : w_exok ? RESP_EXOKAY : RESP_OKAY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (aw_hs) begin
      awaddr_q <= s_axi.awaddr;
      awid_q   <= s_axi.awid;
      awlock_q <= s_axi.awlock;
    end
    if (w_hs) begin
      wdata_q <= s_axi.wdata;
      wstrb_q <= s_axi.wstrb;
    end
  end

  always_ff @(posedge clk) begin
    if (w_fire && w_in && w_ok && !rst)
      for (int b = 0; b < BYTES; b++)
        if (w_strb[b]) mem[w_idx][8*b +: 8] <= w_data[8*b +: 8];
  end

  r_state_e              r_state_q, r_state_d;
  logic                  arready_q, rvalid_q;
  logic [ID_WIDTH-1:0]   rid_q, arid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  resp_t                 rresp_q;
  logic [ADDR_WIDTH-1:0] araddr_q;
  logic                  arlock_q;
  logic [1:0]            cnt_q;
  logic                  ar_hs, r_hs, r_live, r_fire, r_in, r_exok, ar_lock;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ID_WIDTH-1:0]   r_id;
  logic [IDX_W-1:0]      r_idx;

  assign ar_hs     = arready_q && s_axi.arvalid;
  assign r_hs      = rvalid_q && s_axi.rready;
  assign r_live    = r_state_q == R_IDLE;
  assign r_addr    = r_live ? s_axi.araddr : araddr_q;
  assign r_id      = r_live ? s_axi.arid : arid_q;
  assign ar_lock   = r_live ? s_axi.arlock : arlock_q;
  assign r_in      = in_range(r_addr);
  assign r_idx     = to_idx(r_addr);
  assign r_fire    = r_live ? ar_hs && READ_LATENCY == 1 : r_state_q == R_WAIT && cnt_q == 2'd1;
  assign r_state_d = r_fire ? R_RESP : ar_hs ? R_WAIT : r_hs ? R_IDLE : r_state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= r_state_d == R_IDLE;
      rvalid_q  <= r_fire || (rvalid_q && !s_axi.rready);
      if (r_fire) begin
        rid_q   <= r_id;
        rdata_q <= r_in ? mem[r_idx] : '0;
        rresp_q <= !r_in ? RESP_SLVERR : r_exok ? RESP_EXOKAY : RESP_OKAY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ar_hs) begin
      araddr_q <= s_axi.araddr;
      arid_q   <= s_axi.arid;
      arlock_q <= s_axi.arlock;
      cnt_q    <= CNT_INIT;
    end else if (r_state_q == R_WAIT) begin
      cnt_q <= cnt_q - 2'd1;
    end
  end

`ifdef AXI_EXCL_MON_EN
  logic ex_match;
  axi_excl_monitor #(.ID_WIDTH(ID_WIDTH), .IDX_W(IDX_W)) u_excl (
    .clk       (clk),
    .rst       (rst),
    .set_i     (r_fire && ar_lock && r_in),
    .set_id_i  (r_id),
    .set_idx_i (r_idx),
    .wr_i      (w_fire && w_in),
    .wr_excl_i (aw_lock),
    .wr_id_i   (w_id),
    .wr_idx_i  (w_idx),
    .match_o   (ex_match)
  );
  assign w_ok   = !aw_lock || ex_match;
  assign w_exok = aw_lock && ex_match;
  assign r_exok = ar_lock;
  logic unused_ok;
  assign unused_ok = ^{s_axi.awprot, s_axi.arprot};
`else
  assign w_ok   = 1'b1;
  assign w_exok = 1'b0;
  assign r_exok = 1'b0;
  logic unused_ok;
  assign unused_ok = ^{s_axi.awprot, s_axi.arprot, aw_lock, ar_lock};
`endif

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bid     = bid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rid     = rid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;
endmodule

// File: tb/tb_axi_lite_ram_slave.sv
// tb_axi_lite_ram_slave: scoreboard bench for axi_lite_ram_slave (either AXI_EXCL_MON_EN build)
module tb_axi_lite_ram_slave;
  import axi_lite_pkg::*;
  localparam int RL = 1;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_lite_ram_slave_if bus ();
  axi_lite_ram_slave #(.READ_LATENCY(RL)) dut (.clk(clk), .rst(rst), .s_axi(bus));

  typedef struct packed {
    logic [3:0]  id;
    logic [1:0]  resp;
    logic [31:0] data;
  } exp_t;

  exp_t        wq[$];
  exp_t        rq[$];
  logic [31:0] mdl [int];
  logic        res_v = 1'b0;
  logic [3:0]  res_id;
  int          res_idx;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic inr(input logic [31:0] a);
    return (a - BASE) < 32'd4096;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  task automatic model_wr(input logic [31:0] a, d, input logic [3:0] s, id, input logic lk);
    exp_t        e;
    logic        wr;
    logic [31:0] w;
    e    = '0;
    e.id = id;
    wr   = 1'b0;
    if (!inr(a)) e.resp = RESP_SLVERR;
    else begin
      wr     = 1'b1;
      e.resp = RESP_OKAY;
`ifdef AXI_EXCL_MON_EN
      if (lk) begin
        wr     = res_v && res_id == id && res_idx == widx(a);
        e.resp = wr ? RESP_EXOKAY : RESP_OKAY;
        if (wr) res_v = 1'b0;
      end else if (res_v && res_idx == widx(a)) res_v = 1'b0;
`endif
    end
    if (wr) begin
      w = mdl.exists(widx(a)) ? mdl[widx(a)] : 32'hx;
      for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
      mdl[widx(a)] = w;
    end
    wq.push_back(e);
  endtask

  task automatic model_rd(input logic [31:0] a, input logic [3:0] id, input logic lk);
    exp_t e;
    e    = '0;
    e.id = id;
    if (!inr(a)) e.resp = RESP_SLVERR;
    else begin
      e.resp = RESP_OKAY;
      e.data = mdl[widx(a)];
`ifdef AXI_EXCL_MON_EN
      if (lk) begin
        e.resp  = RESP_EXOKAY;
        res_v   = 1'b1;
        res_id  = id;
        res_idx = widx(a);
      end
`endif
    end
    rq.push_back(e);
  endtask

  task automatic wr_req(input logic [31:0] a, d, input logic [3:0] s, id, input logic lk, input int lead);
    exp_t e;
    int   n;
    model_wr(a, d, s, id, lk);
    bus.awaddr = a; bus.awid = id; bus.awlock = lk; bus.awprot = 3'($urandom_range(0, 7));
    bus.wdata = d; bus.wstrb = s;
    n = 0;
    while (!(bus.awready && bus.wready) && n < 20) begin step(); n++; end
    chk("w_rdy", {bus.awready, bus.wready}, 2'b11);
    if (lead == 0) begin
      bus.awvalid = 1'b1; bus.wvalid = 1'b1;
      step();
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    end else begin
      bus.wvalid = 1'b1;
      step();
      bus.wvalid = 1'b0;
      chk("w_drop", bus.wready, 1'b0);
      repeat (lead - 1) step();
      chk("b_early", bus.bvalid, 1'b0);
      bus.awvalid = 1'b1;
      step();
      bus.awvalid = 1'b0;
    end
    chk("b_lat", bus.bvalid, 1'b1);
    e = wq.pop_front();
    chk("bid", bus.bid, e.id);
    chk("bresp", bus.bresp, e.resp);
  endtask

  task automatic b_acc();
    bus.bready = 1'b1;
    step();
    bus.bready = 1'b0;
    chk("b_done", bus.bvalid, 1'b0);
    chk("aw_back", bus.awready, 1'b1);
  endtask

  task automatic rd(input logic [31:0] a, input logic [3:0] id, input logic lk, input int stall);
    exp_t e;
    int   n;
    model_rd(a, id, lk);
    bus.araddr = a; bus.arid = id; bus.arlock = lk; bus.arprot = 3'($urandom_range(0, 7));
    n = 0;
    while (!bus.arready && n < 20) begin step(); n++; end
    chk("ar_rdy", bus.arready, 1'b1);
    bus.arvalid = 1'b1;
    step();
    bus.arvalid = 1'b0;
    chk("ar_drop", bus.arready, 1'b0);
    for (int k = 1; k < RL; k++) begin
      chk("r_early", bus.rvalid, 1'b0);
      step();
    end
    chk("r_lat", bus.rvalid, 1'b1);
    e = rq.pop_front();
    chk("rid", bus.rid, e.id);
    chk("rdata", bus.rdata, e.data);
    chk("rresp", bus.rresp, e.resp);
    repeat (stall) begin
      step();
      chk("r_hold_v", bus.rvalid, 1'b1);
      chk("r_hold_d", bus.rdata, e.data);
      chk("r_hold_id", bus.rid, e.id);
      chk("r_hold_ar", bus.arready, 1'b0);
    end
    bus.rready = 1'b1;
    step();
    bus.rready = 1'b0;
    chk("r_done", bus.rvalid, 1'b0);
    chk("ar_back", bus.arready, 1'b1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    bus.awvalid = 1'b0; bus.awid = '0; bus.awaddr = '0; bus.awprot = '0; bus.awlock = 1'b0;
    bus.wvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.bready = 1'b0;
    bus.arvalid = 1'b0; bus.arid = '0; bus.araddr = '0; bus.arprot = '0; bus.arlock = 1'b0;
    bus.rready = 1'b0;
    repeat (3) step();
    chk("rst_out", {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid}, 5'b0);
    rst = 1'b0;
    step();
    chk("rdy_up", {bus.awready, bus.wready, bus.arready}, 3'b111);

    wr_req(BASE + 32'h10, 32'hDEADBEEF, 4'hF, 4'd5, 1'b0, 0);
    b_acc();
    rd(BASE + 32'h10, 4'd2, 1'b0, 5);

    wr_req(BASE + 32'h10, 32'h0000_1234, 4'h3, 4'd6, 1'b0, 3);
    b_acc();
    rd(BASE + 32'h12, 4'd9, 1'b0, 0);

    wr_req(BASE, 32'h1111_1111, 4'hF, 4'd1, 1'b0, 0);
    b_acc();
    wr_req(BASE + 32'h1000, 32'hFFFF_FFFF, 4'hF, 4'd1, 1'b0, 0);
    b_acc();
    rd(BASE, 4'd1, 1'b0, 0);
    rd(32'h0FFF_FFFC, 4'd4, 1'b0, 1);

    wr_req(BASE + 32'h20, 32'hAAAA_0000, 4'hF, 4'd3, 1'b0, 0);
    b_acc();
    rd(BASE + 32'h20, 4'd3, 1'b1, 0);
    wr_req(BASE + 32'h20, 32'h1234_5678, 4'hF, 4'd3, 1'b1, 0);
    b_acc();
    wr_req(BASE + 32'h20, 32'h9999_9999, 4'hF, 4'd3, 1'b1, 2);
    b_acc();
    rd(BASE + 32'h20, 4'd3, 1'b0, 0);

    for (int i = 0; i < 8; i++) begin
      logic [31:0] a;
      a = BASE + 32'(256 + 4 * i);
      wr_req(a, $urandom, 4'hF, 4'($urandom_range(0, 15)), 1'b0, $urandom_range(0, 2));
      b_acc();
      wr_req(a, $urandom, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0, $urandom_range(0, 3));
      b_acc();
      rd(a, 4'($urandom_range(0, 15)), 1'b0, $urandom_range(0, 3));
    end

    wr_req(BASE + 32'h30, 32'hCAFE_F00D, 4'hF, 4'd7, 1'b0, 0);
    rst = 1'b1;
    step();
    chk("rst_bv", bus.bvalid, 1'b0);
    chk("rst_aw0", bus.awready, 1'b0);
    step();
    chk("rst_aw1", bus.awready, 1'b0);
    rst = 1'b0;
    res_v = 1'b0;
    step();
    chk("rel_aw", bus.awready, 1'b1);
    chk("rel_bv", bus.bvalid, 1'b0);
    rd(BASE + 32'h30, 4'd8, 1'b0, 0);
    rd(BASE + 32'h10, 4'd2, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
